// File: rtl/mux_n_1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mux_n_1_rr
//  Purpose  : N:1 stream multiplexer, round-robin or fixed-select arbitration,
//             single registered output stage with valid/ready handshakes.
//  Revision : 1.0  initial release
// ============================================================================
module mux_n_1_rr #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  y,
    input  logic [N-1:0]    y_valid,
    output logic [N-1:0]    y_ready,
    input  logic            mode,
    input  logic [SW-1:0]   s,
    output logic [W-1:0]    x,
    output logic            x_valid,
    input  logic            x_ready,
    output logic [SW-1:0]   x_ch
);

    logic [W-1:0]  r_x;
    logic [SW-1:0] r_x_ch;
    logic          r_x_valid;
    logic [SW-1:0] r_ptr;

    logic          w_load_en;
    logic          w_has_grant;
    logic [SW-1:0] w_grant;
    logic [W-1:0]  w_data;
    int            w_idx;

    assign w_load_en = !r_x_valid || x_ready;

    always_comb begin
        w_has_grant = 1'b0;
        w_grant     = '0;
        w_idx       = 0;
        if (mode) begin
            // An out-of-range select simply never matches any channel.
            for (int k = 0; k < N; k++) begin
                if (s == SW'(k) && y_valid[k]) begin
                    w_has_grant = 1'b1;
                    w_grant     = SW'(k);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                w_idx = (int'(r_ptr) + i) % N;
                if (!w_has_grant && y_valid[w_idx]) begin
                    w_has_grant = 1'b1;
                    w_grant     = SW'(w_idx);
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant == SW'(k)) begin
                w_data = y[k*W +: W];
            end
        end
    end

    // Gated by rst_n so no channel sees an accept while reset is held.
    always_comb begin
        y_ready = '0;
        if (rst_n && w_load_en && w_has_grant) begin
            y_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x       <= '0;
            r_x_ch    <= '0;
            r_x_valid <= 1'b0;
            r_ptr     <= '0;
        end else if (w_load_en) begin
            r_x_valid <= w_has_grant;
            if (w_has_grant) begin
                r_x    <= w_data;
                r_x_ch <= w_grant;
                if (!mode) begin
                    r_ptr <= (w_grant == SW'(N-1)) ? '0 : w_grant + SW'(1);
                end
            end
        end
    end

    assign x       = r_x;
    assign x_ch    = r_x_ch;
    assign x_valid = r_x_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_n_1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_n_1_rr
//  Purpose  : Scoreboard bench for mux_n_1_rr (N=4 main instance, N=3 for
//             out-of-range select).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_n_1_rr;

    localparam int C_N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] y;
    logic [3:0]  y_valid;
    logic [3:0]  y_ready;
    logic        mode;
    logic [1:0]  s;
    logic [7:0]  x;
    logic        x_valid;
    logic        x_ready;
    logic [1:0]  x_ch;

    logic [23:0] y3;
    logic [2:0]  y_valid3;
    logic [2:0]  y_ready3;
    logic        mode3;
    logic [1:0]  s3;
    logic [7:0]  x3;
    logic        x_valid3;
    logic        x_ready3;
    logic [1:0]  x_ch3;

    always #5 clk = ~clk;

    mux_n_1_rr #(.N(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n), .y(y), .y_valid(y_valid), .y_ready(y_ready),
        .mode(mode), .s(s), .x(x), .x_valid(x_valid), .x_ready(x_ready), .x_ch(x_ch)
    );

    mux_n_1_rr #(.N(3), .W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .y(y3), .y_valid(y_valid3), .y_ready(y_ready3),
        .mode(mode3), .s(s3), .x(x3), .x_valid(x_valid3), .x_ready(x_ready3), .x_ch(x_ch3)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: output occupancy and round-robin start position.
    logic       m_xv;
    int         m_ptr;
    logic [3:0] exp_yready;
    logic [9:0] exp_q[$];
    logic       mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_xv  = 1'b0;
        m_ptr = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, predict the grant, advance past the edge.
    task automatic drive_cycle(input logic [3:0] yv, input logic [31:0] yd,
                               input logic md, input logic [1:0] sel, input logic xr);
        logic le;
        int   g;
        y_valid = yv; y = yd; mode = md; s = sel; x_ready = xr;
        le = !m_xv || xr;
        g  = -1;
        if (md) begin
            if (int'(sel) < C_N && yv[sel]) g = int'(sel);
        end else begin
            for (int off = 0; off < C_N; off++) begin
                int c;
                c = (m_ptr + off) % C_N;
                if (g < 0 && yv[c]) g = c;
            end
        end
        exp_yready = (le && g >= 0) ? (4'b0001 << g) : 4'b0000;
        if (le && g >= 0) exp_q.push_back({yd[g*8 +: 8], g[1:0]});
        mon_en = 1'b1;
        @(posedge clk); #1;
        if (le) begin
            if (g >= 0) begin
                m_xv = 1'b1;
                if (!md) m_ptr = (g + 1) % C_N;
            end else begin
                m_xv = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            logic [9:0] e;
            check("y_ready", {28'd0, y_ready}, {28'd0, exp_yready});
            check("x_valid", {31'd0, x_valid}, {31'd0, m_xv});
            if (x_valid && x_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_x", {24'd0, x}, {24'd0, e[9:2]});
                    check("sb_x_ch", {30'd0, x_ch}, {30'd0, e[1:0]});
                end
            end
        end
    end

    localparam logic [31:0] C_ALL = {8'h44, 8'h33, 8'h22, 8'h11};

    initial begin
        rst_n = 1'b0;
        y = '0; y_valid = '0; mode = 1'b0; s = '0; x_ready = 1'b0;
        y3 = '0; y_valid3 = '0; mode3 = 1'b1; s3 = 2'd3; x_ready3 = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_x_valid", {31'd0, x_valid}, 32'd0);
        check("rst_x", {24'd0, x}, 32'd0);
        check("rst_x_ch", {30'd0, x_ch}, 32'd0);

        // Round-robin fairness over all-valid inputs.
        for (int i = 0; i < 5; i++) begin
            drive_cycle(4'b1111, C_ALL, 1'b0, 2'd0, 1'b1);
            check("rr_x_ch", {30'd0, x_ch}, i % 4);
            check("rr_x", {24'd0, x}, ((i % 4) + 1) * 32'h11);
        end

        // Move ptr to 3, then skip and wrap on a sparse valid pattern.
        drive_cycle(4'b0100, C_ALL, 1'b0, 2'd0, 1'b1);
        check("ptr3_x_ch", {30'd0, x_ch}, 32'd2);
        drive_cycle(4'b0101, C_ALL, 1'b0, 2'd0, 1'b1);
        check("wrap_x_ch", {30'd0, x_ch}, 32'd0);
        drive_cycle(4'b0101, C_ALL, 1'b0, 2'd0, 1'b1);
        check("skip_x_ch", {30'd0, x_ch}, 32'd2);

        // Backpressure: hold for three cycles, then drain and reload together.
        drive_cycle(4'b1111, C_ALL, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(4'b1111, C_ALL, 1'b0, 2'd0, 1'b0);
            check("bp_x", {24'd0, x}, 32'h44);
            check("bp_x_ch", {30'd0, x_ch}, 32'd3);
        end
        drive_cycle(4'b1111, C_ALL, 1'b0, 2'd0, 1'b1);
        check("bp_reload_x_ch", {30'd0, x_ch}, 32'd0);
        check("bp_reload_x", {24'd0, x}, 32'h11);

        // Fixed mode: no grant drops x_valid; grant on channel 2; ptr untouched.
        drive_cycle(4'b1011, C_ALL, 1'b1, 2'd2, 1'b1);
        check("fix_nogrant_valid", {31'd0, x_valid}, 32'd0);
        drive_cycle(4'b0100, C_ALL, 1'b1, 2'd2, 1'b1);
        check("fix_x_ch", {30'd0, x_ch}, 32'd2);
        drive_cycle(4'b1111, C_ALL, 1'b0, 2'd0, 1'b1);
        check("fix_ptr_kept", {30'd0, x_ch}, 32'd1);

        for (int i = 0; i < 1500; i++) begin
            drive_cycle(4'($urandom), $urandom, ($urandom_range(3) == 0),
                        2'($urandom), ($urandom_range(3) != 0));
        end

        // Asynchronous reset between edges discards a held word.
        drive_cycle(4'b1111, C_ALL, 1'b0, 2'd0, 1'b0);
        drive_cycle(4'b1111, C_ALL, 1'b0, 2'd0, 1'b0);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_x_valid", {31'd0, x_valid}, 32'd0);
        check("arst_x", {24'd0, x}, 32'd0);
        check("arst_x_ch", {30'd0, x_ch}, 32'd0);
        check("arst_y_ready", {28'd0, y_ready}, 32'd0);
        #1 rst_n = 1'b1;
        model_reset();
        drive_cycle(4'b1010, C_ALL, 1'b0, 2'd0, 1'b1);
        check("post_rst_x_ch", {30'd0, x_ch}, 32'd1);
        drive_cycle(4'b1111, C_ALL, 1'b0, 2'd0, 1'b1);
        check("post_rst_next", {30'd0, x_ch}, 32'd2);
        mon_en = 1'b0;

        // Out-of-range fixed select on the three-channel instance.
        for (int i = 0; i < 16; i++) begin
            y_valid3 = 3'($urandom);
            y3       = 24'($urandom);
            x_ready3 = 1'($urandom);
            #2;
            check("oor_y_ready", {29'd0, y_ready3}, 32'd0);
            @(posedge clk); #1;
            check("oor_x_valid", {31'd0, x_valid3}, 32'd0);
        end

        check("sb_drained_or_pending", {31'd0, exp_q.size() <= 1}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
